ksa_sub_pipe: RTL and testbench

//  Pipelined WIDTH-bit Kogge-Stone subtractor, the inverse operation to the team's KSA adder.

---
 rtl/ksa_sub_if.sv | 26 ++
 rtl/ksa_sub_pipe.sv | 108 ++++++++++
 tb/tb_ksa_sub_pipe.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ksa_sub_if.sv
// Operand/result handshake bundle for the pipelined Kogge-Stone subtractor.
interface ksa_sub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero
  );
endinterface

// File: rtl/ksa_sub_pipe.sv
// 3-stage pipelined Kogge-Stone subtractor: diff = a + ~b + ~bin.
// Prefix levels are split across S2/S3; one global enable stalls all stages.
module ksa_sub_pipe #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  ksa_sub_if.slave io
);
  localparam int LOG2W = $clog2(WIDTH);
  localparam int L1    = (LOG2W + 1) / 2;

  logic en;
  logic v1, v2, v3;

  logic [WIDTH-1:0] bb, p0, g0;

  logic [WIDTH-1:0] s1_p, s1_g;
  logic             s1_c0, s1_am, s1_bm;

  logic [WIDTH-1:0] s2_g, s2_p, s2_pp;
  logic             s2_c0, s2_am, s2_bm;

  logic [WIDTH-1:0] s3_diff;
  logic             s3_bout, s3_ovf, s3_zero;

  logic [WIDTH-1:0] tg [LOG2W+1];
  logic [WIDTH-1:0] tp [LOG2W+1];

  logic [WIDTH-1:0] c, sum;

  assign en          = io.out_ready | ~v3;
  assign io.in_ready = en;
  assign io.out_valid = v3;
  assign io.diff     = s3_diff;
  assign io.bout     = s3_bout;
  assign io.ovf      = s3_ovf;
  assign io.zero     = s3_zero;

  assign bb = ~io.b;
  assign p0 = io.a ^ bb;
  assign g0 = io.a & bb;

  assign tg[0] = s1_g;
  assign tp[0] = s1_p;

  // Bits below the stride have no partner and pass through as buffers.
  for (genvar k = 0; k < LOG2W; k++) begin : g_lvl
    localparam int S = 1 << k;
    localparam logic [WIDTH-1:0] LOW =
      (WIDTH'(1) << S) - WIDTH'(1);
    logic [WIDTH-1:0] gi, pi;
    if (k == L1) begin : g_cut
      assign gi = s2_g;
      assign pi = s2_p;
    end else begin : g_thru
      assign gi = tg[k];
      assign pi = tp[k];
    end
    assign tg[k+1] = gi | (pi & (gi << S));
    assign tp[k+1] = pi & ((pi << S) | LOW);
  end

  assign c   = tg[LOG2W] | (tp[LOG2W] & {WIDTH{s2_c0}});
  assign sum = s2_pp ^ {c[WIDTH-2:0], s2_c0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      s1_p    <= '0;
      s1_g    <= '0;
      s1_c0   <= 1'b0;
      s1_am   <= 1'b0;
      s1_bm   <= 1'b0;
      s2_g    <= '0;
      s2_p    <= '0;
      s2_pp   <= '0;
      s2_c0   <= 1'b0;
      s2_am   <= 1'b0;
      s2_bm   <= 1'b0;
      s3_diff <= '0;
      s3_bout <= 1'b0;
      s3_ovf  <= 1'b0;
      s3_zero <= 1'b0;
    end else if (en) begin
      v1      <= io.in_valid;
      v2      <= v1;
      v3      <= v2;
      s1_p    <= p0;
      s1_g    <= g0;
      s1_c0   <= ~io.bin;
      s1_am   <= io.a[WIDTH-1];
      s1_bm   <= io.b[WIDTH-1];
      s2_g    <= tg[L1];
      s2_p    <= tp[L1];
      s2_pp   <= s1_p;
      s2_c0   <= s1_c0;
      s2_am   <= s1_am;
      s2_bm   <= s1_bm;
      s3_diff <= sum;
      s3_bout <= ~c[WIDTH-1];
      s3_ovf  <= (s2_am ^ s2_bm) & (sum[WIDTH-1] ^ s2_am);
      s3_zero <= ~|sum;
    end
  end
endmodule

// File: tb/tb_ksa_sub_pipe.sv
// Bench for ksa_sub_pipe: directed vector table, stall/reset sequences,
// and a randomized scoreboard run against a 33-bit subtraction model.
module tb_ksa_sub_pipe;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ksa_sub_if #(.WIDTH(W)) io ();
  ksa_sub_pipe #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  int checks = 0;
  int failures = 0;
  int rcvd = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    logic         z;
  } vec_t;

  vec_t vt [10];
  logic [W+2:0] q [$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Result packed as {ovf, zero, bout, diff}.
  function automatic logic [W+2:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic bin);
    logic [W:0] r;
    logic       ov;
    r  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    return {ov, (r[W-1:0] == '0), r[W], r[W-1:0]};
  endfunction

  logic         hold = 1'b0;
  logic [W+2:0] held;
  logic [W+2:0] cur;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold = 1'b0;
    end else begin
      cur = {io.ovf, io.zero, io.bout, io.diff};
      if (hold) begin
        chk("stable_valid", 64'(io.out_valid), 64'(1));
        chk("stable_data", 64'(cur), 64'(held));
      end
      if (io.out_valid && io.out_ready) begin
        if (q.size() == 0) chk("unexpected_beat", 64'(1), 64'(0));
        else chk("result", 64'(cur), 64'(q.pop_front()));
        rcvd++;
      end
      if (io.in_valid && io.in_ready)
        q.push_back(model(io.a, io.b, io.bin));
      hold = io.out_valid && !io.out_ready;
      held = cur;
    end
  end

  task automatic run_one(input vec_t v, input string nm);
    int e;
    e = 0;
    io.a = v.a;
    io.b = v.b;
    io.bin = v.bin;
    io.in_valid = 1'b1;
    do begin
      @(posedge clk);
      #1;
      io.in_valid = 1'b0;
      e++;
    end while (!io.out_valid && e < 10);
    chk($sformatf("%s_lat", nm), 64'(e), 64'(3));
    chk(nm, 64'({io.ovf, io.zero, io.bout, io.diff}),
        64'({v.ov, v.z, v.bo, v.d}));
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int n, input bit rnd,
                        input int st_at, input int st_len);
    int  sent, cyc, r0;
    bit  acc;
    sent = 0;
    cyc = 0;
    r0 = rcvd;
    while (sent < n && cyc < n * 20 + 100) begin
      if (rnd) io.out_ready = ($urandom_range(0, 3) != 0);
      else io.out_ready = !(cyc >= st_at && cyc < st_at + st_len);
      if (!io.in_valid && (!rnd || $urandom_range(0, 3) != 0)) begin
        if (rnd) begin
          io.a = $urandom;
          io.b = $urandom;
          io.bin = 1'($urandom_range(0, 1));
        end else begin
          io.a = W'(sent) * 32'h1111_1111;
          io.b = W'(sent) * 32'h0700_0007;
          io.bin = sent[0];
        end
        io.in_valid = 1'b1;
      end
      @(negedge clk);
      if (!rnd && !io.out_ready)
        chk("stall_in_ready", 64'(io.in_ready), 64'(0));
      acc = io.in_valid && io.in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        sent++;
        io.in_valid = 1'b0;
      end
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    cyc = 0;
    while ((q.size() != 0 || io.out_valid) && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("sent", 64'(sent), 64'(n));
    chk("rcvd", 64'(rcvd - r0), 64'(n));
    chk("queue_empty", 64'(q.size()), 64'(0));
  endtask

  initial begin
    vt[0] = '{32'd5, 32'd3, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0};
    vt[1] = '{32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vt[2] = '{32'd7, 32'd7, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1};
    vt[3] = '{32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vt[4] = '{32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF,
              1'b0, 1'b1, 1'b0};
    vt[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000,
              1'b1, 1'b1, 1'b0};
    vt[6] = '{32'h1234_5678, 32'h0234_5678, 1'b1, 32'h0FFF_FFFF,
              1'b0, 1'b0, 1'b0};
    vt[7] = '{32'h0001_0000, 32'd0, 1'b1, 32'h0000_FFFF,
              1'b0, 1'b0, 1'b0};
    vt[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0,
              1'b0, 1'b0, 1'b1};
    vt[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF,
              1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    io.in_valid = 1'b0;
    io.a = '0;
    io.b = '0;
    io.bin = 1'b0;
    io.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(io.out_valid), 64'(0));
    chk("rst_flags", 64'({io.ovf, io.zero, io.bout, io.diff}), 64'(0));
    chk("rst_in_ready", 64'(io.in_ready), 64'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++)
      run_one(vt[i], $sformatf("vec%0d", i));

    stream(10, 1'b0, 5, 4);

    io.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      io.a = 32'd100 + 32'(i);
      io.b = 32'd1;
      io.bin = 1'b0;
      io.in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    io.in_valid = 1'b0;
    chk("pre_rst_full", 64'(io.out_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(io.out_valid), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    io.out_ready = 1'b1;
    chk("post_rst_in_ready", 64'(io.in_ready), 64'(1));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("no_stale_beat", 64'(io.out_valid), 64'(0));
    end
    run_one(vt[5], "post_rst");

    stream(10000, 1'b1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
